// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain line enables.
// Define PS2_TX_RETRY_EN to retry a failed frame once before reporting an error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_REL,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_nextState;
  state_t w_failState;

  logic             r_clkMeta;
  logic             r_clkSync;
  logic             r_clkPrev;
  logic             r_dataMeta;
  logic             r_dataSync;
  logic [7:0]       r_txByte;
  logic             r_parity;
  logic [INH_W-1:0] r_inhCnt;
  logic [TO_W-1:0]  r_toCnt;
  logic [3:0]       r_bitCnt;
  logic             r_dataOe;

  logic w_accept;
  logic w_clkFall;
  logic w_timing;
  logic w_timeout;
  logic w_inhDone;
  logic w_released;
  logic w_sendBit;

  // Idle lines float high, so the synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clkMeta  <= 1'b1;
      r_clkSync  <= 1'b1;
      r_clkPrev  <= 1'b1;
      r_dataMeta <= 1'b1;
      r_dataSync <= 1'b1;
    end else begin
      r_clkMeta  <= ps2_clk_in;
      r_clkSync  <= r_clkMeta;
      r_clkPrev  <= r_clkSync;
      r_dataMeta <= ps2_data_in;
      r_dataSync <= r_dataMeta;
    end
  end

  assign w_accept   = (r_state == S_IDLE) && tx_valid;
  assign w_clkFall  = r_clkPrev && !r_clkSync;
  assign w_timing   = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_REL);
  assign w_timeout  = w_timing && (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_inhDone  = (r_inhCnt == INH_W'(INHIBIT_CYCLES - 1));
  assign w_released = r_clkSync && r_dataSync;
  assign w_sendBit  = (r_state == S_SEND) && w_clkFall && !w_timeout;

`ifdef PS2_TX_RETRY_EN
  logic r_retried;
  logic w_failEvent;

  assign w_failEvent = w_timeout || ((r_state == S_ACK) && w_clkFall && r_dataSync);
  assign w_failState = r_retried ? S_ERROR : S_INHIBIT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retried <= 1'b0;
    end else if (w_accept) begin
      r_retried <= 1'b0;
    end else if (w_failEvent) begin
      r_retried <= 1'b1;
    end
  end
`else
  assign w_failState = S_ERROR;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Timeout is checked before edge handling so it wins on a coincident fall.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:     if (tx_valid) w_nextState = S_INHIBIT;
      S_INHIBIT:  if (w_inhDone) w_nextState = S_REQ;
      S_REQ:      w_nextState = S_SEND;
      S_SEND: begin
        if (w_timeout) w_nextState = w_failState;
        else if (w_clkFall && (r_bitCnt == 4'd9)) w_nextState = S_ACK;
      end
      S_ACK: begin
        if (w_timeout) w_nextState = w_failState;
        else if (w_clkFall) w_nextState = r_dataSync ? w_failState : S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (w_timeout) w_nextState = w_failState;
        else if (w_released) w_nextState = S_IDLE;
      end
      S_ERROR:    w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready    = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    tx_done     = (r_state == S_WAIT_REL) && w_released && !w_timeout;
    tx_error    = (r_state == S_ERROR);
    ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_REQ);
    ps2_data_oe = (r_state == S_REQ) || ((r_state == S_SEND) && r_dataOe);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_txByte <= '0;
      r_parity <= 1'b0;
      r_inhCnt <= '0;
      r_toCnt  <= '0;
      r_bitCnt <= '0;
      r_dataOe <= 1'b0;
    end else begin
      if (w_accept) begin
        r_txByte <= tx_data;
        r_parity <= ~^tx_data;
      end

      r_inhCnt <= (r_state == S_INHIBIT) ? r_inhCnt + 1'b1 : '0;

      if (r_state == S_REQ) r_toCnt <= '0;
      else if (w_timing)    r_toCnt <= r_toCnt + 1'b1;

      // Fall n presents bit n-1; the start bit is already on the line from REQ.
      if (r_state == S_REQ) begin
        r_bitCnt <= '0;
        r_dataOe <= 1'b1;
      end else if (w_sendBit) begin
        r_bitCnt <= r_bitCnt + 1'b1;
        if (r_bitCnt < 4'd8)       r_dataOe <= ~r_txByte[r_bitCnt[2:0]];
        else if (r_bitCnt == 4'd8) r_dataOe <= ~r_parity;
        else                       r_dataOe <= 1'b0;
      end
    end
  end

endmodule
